pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard controller for the 5-stage pipeline. Drives stall/flush of the F->D and D->E pipeline
//  registers and the forwarding muxes. Detects load-use and branch-compare hazards, and handles
//  jump/branch redirects. Sequences the multi-cycle multiply/divide unit with an internal
//  busy FSM, so dependent HI/LO reads and new MD ops wait until the result is ready.
// PARAMETERS
//  MD_LATENCY  32  cycles the mult/div unit needs after mdStartE before HI/LO are valid (>=2)
//  CNT_W        6  width of the MD countdown counter; must satisfy 2**CNT_W > MD_LATENCY
// PORTS
//  clk         in   1  pipeline clock; all state updates on posedge
//  reset_n     in   1  asynchronous, active-low reset
//  rsD, rtD    in   5  source regs of the instruction in Decode
//  rsE, rtE    in   5  source regs of the instruction in Execute
//  writeRegE   in   5  destination reg in Execute
//  writeRegM   in   5  destination reg in Memory
//  writeRegW   in   5  destination reg in Writeback
//  regWriteE   in   1  Execute instruction writes the register file
//  regWriteM   in   1  Memory instruction writes the register file
//  regWriteW   in   1  Writeback instruction writes the register file
//  memToRegE   in   1  Execute instruction is a load
//  memToRegM   in   1  Memory instruction is a load
//  branchD     in   1  Decode instruction is a conditional branch
//  PCSrcD      in   1  Decode redirects the PC (taken branch or jump)
//  mdOpD       in   1  Decode instruction is mult/div or mfhi/mflo
//  mdStartE    in   1  a mult/div is in Execute this cycle (one-cycle start pulse)
//  stallF      out  1  hold the PC
//  stallD      out  1  hold the F->D register
//  flushD      out  1  clear the F->D register
//  flushE      out  1  clear the D->E register (insert a bubble)
//  forwardAD   out  1  Decode srcA takes the ALUOutM bypass
//  forwardBD   out  1  Decode srcB takes the ALUOutM bypass
//  forwardAE   out  2  Execute srcA: 00 regfile, 01 resultW, 10 ALUOutM
//  forwardBE   out  2  Execute srcB: encoded as forwardAE
//  mdBusy      out  1  MD FSM is not IDLE
// BEHAVIOUR
//  Register 0 never matches in any hazard or forward compare.
//  Forwarding (combinational):
//   - forwardAE = 10 if regWriteM & writeRegM==rsE.
//   - Otherwise forwardAE = 01 if regWriteW & writeRegW==rsE.
//   - Otherwise forwardAE = 00. forwardBE uses the same rules on rtE.
//   - forwardAD = regWriteM & writeRegM==rsD. forwardBD uses the same rule on rtD.
//  Load-use stall: lwStall = memToRegE & (writeRegE==rsD | writeRegE==rtD).
//  Branch stall: brStall = branchD & [(regWriteE & writeRegE in {rsD,rtD})
//   | (memToRegM & writeRegM in {rsD,rtD})].
//  MD FSM states: IDLE, BUSY, DONE.
//   - IDLE -> BUSY on mdStartE; the counter loads MD_LATENCY-1.
//   - BUSY: the counter decrements each cycle; BUSY -> DONE when the counter is 0.
//   - DONE -> IDLE after one cycle (HI/LO are written in this cycle).
//   - mdStartE while in BUSY or DONE is a protocol error; it is ignored and the state is unchanged.
//  mdStall = mdOpD & (state != IDLE | mdStartE).
//  Stall and flush outputs:
//   - stallF = stallD = lwStall | brStall | mdStall.
//   - flushE = lwStall | brStall | mdStall.
//   - flushD = PCSrcD & ~stallD. A redirect is never taken from a stalled Decode.
//  Latency: all outputs except mdBusy are combinational, same cycle.
//   - mdStall first deasserts in the cycle after DONE.
//  Simultaneous hazards: the stall sources are OR-ed together. Flush and stall of the same
//   register never assert together.
//  Reset (async, reset_n=0): state=IDLE, counter=0, mdBusy=0, stallF/stallD/flushD/flushE=0,
//   forwards=0, regardless of the inputs.
//   - Reset asserted mid-BUSY aborts the operation. The first mdStartE after release starts cleanly.
// TESTING
//  1. Load then use: memToRegE=1, writeRegE=8, rsD=8 -> stallF=stallD=flushE=1 for 1 cycle.
//  2. Bypass: regWriteM=1, writeRegM=9, rsE=9, plus regWriteW=1, writeRegW=9
//     -> forwardAE=10 (Memory wins). Same case with writeRegM=0 -> forwardAE=01.
//  3. Branch hazard: branchD=1, rtD=4, regWriteE=1, writeRegE=4 -> stall 1 cycle.
//     Then PCSrcD=1 -> flushD=1 with stallD=0.
//  4. MD_LATENCY=4: pulse mdStartE, hold mdOpD=1 -> mdBusy high 5 cycles, stall held through
//     DONE, released on cycle 6.
//  5. Reset mid-op: drop reset_n 2 cycles after mdStartE -> mdBusy=0 and all stalls 0
//     immediately. A new mdStartE then gives the full latency.
//  6. Zero register: writeRegE=0, memToRegE=1, rsD=0 -> no stall. Forwards stay 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller port bundle: the pipeline-stage register/control fields
// in, stall/flush/forward select and MD busy out.
// Ports: master = pipeline side, drives stage info and reads controls;
//        slave  = hazard controller, reads stage info and drives controls.
interface pipeline_hazard_ctrl_if;
  // Source/destination register numbers per stage
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeRegE;
  logic [4:0] writeRegM;
  logic [4:0] writeRegW;
  // Per-stage control bits
  logic       regWriteE;
  logic       regWriteM;
  logic       regWriteW;
  logic       memToRegE;
  logic       memToRegM;
  logic       branchD;
  logic       PCSrcD;
  logic       mdOpD;
  logic       mdStartE;
  // Controls back to the pipeline
  logic       stallF;
  logic       stallD;
  logic       flushD;
  logic       flushE;
  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       mdBusy;

  modport master (
    output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
    output regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
    output branchD, PCSrcD, mdOpD, mdStartE,
    input  stallF, stallD, flushD, flushE,
    input  forwardAD, forwardBD, forwardAE, forwardBE, mdBusy
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
    input  regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
    input  branchD, PCSrcD, mdOpD, mdStartE,
    output stallF, stallD, flushD, flushE,
    output forwardAD, forwardBD, forwardAE, forwardBE, mdBusy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use / branch-compare
// stalls, jump/branch flush, E and D stage bypass selects, MD busy sequencing.
// Ports: clk, reset_n (async active-low), hz (slave modport of the bundle).
// Latency: all controls combinational same cycle; mdBusy comes from the FSM state.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,  // cycles after mdStartE until HI/LO valid, >= 2
  parameter int CNT_W      = 6    // countdown width, 2**CNT_W > MD_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_t        state;
  md_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Register 0 is hard-wired zero, so a write to it never creates a hazard.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // ---------------------------------------------------------------------
  // MD busy FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (hz.mdStartE) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // A start pulse here is a protocol error and is simply ignored.
        if (cnt == '0) begin
          state_nxt = MD_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      MD_DONE: begin
        // HI/LO are written this cycle; dependents may issue from the next.
        state_nxt = MD_IDLE;
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic any_stall;

  assign lw_stall = hz.memToRegE &
                    (reg_hit(hz.writeRegE, hz.rsD) | reg_hit(hz.writeRegE, hz.rtD));

  // Branches compare in Decode, so an ALU result still in E, or a load
  // still in M, cannot be bypassed in time.
  assign br_stall = hz.branchD &
                    ((hz.regWriteE &
                      (reg_hit(hz.writeRegE, hz.rsD) | reg_hit(hz.writeRegE, hz.rtD))) |
                     (hz.memToRegM &
                      (reg_hit(hz.writeRegM, hz.rsD) | reg_hit(hz.writeRegM, hz.rtD))));

  // The start cycle itself counts as busy: the FSM only leaves IDLE next cycle.
  assign md_stall = hz.mdOpD & ((state != MD_IDLE) | hz.mdStartE);

  assign any_stall = lw_stall | br_stall | md_stall;

  // ---------------------------------------------------------------------
  // Forwarding selects
  // ---------------------------------------------------------------------
  logic [1:0] fwd_ae;
  logic [1:0] fwd_be;

  // Memory holds the younger result, so it takes priority over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hz.regWriteM && reg_hit(hz.writeRegM, src)) return 2'b10;
    if (hz.regWriteW && reg_hit(hz.writeRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_ae = fwd_sel(hz.rsE);
  assign fwd_be = fwd_sel(hz.rtE);

  // ---------------------------------------------------------------------
  // Outputs: forced quiet while reset is asserted, whatever the inputs do.
  // ---------------------------------------------------------------------
  assign hz.stallF    = reset_n & any_stall;
  assign hz.stallD    = reset_n & any_stall;
  assign hz.flushE    = reset_n & any_stall;
  // A redirect out of a stalled Decode would act on stale operands.
  assign hz.flushD    = reset_n & hz.PCSrcD & ~any_stall;
  assign hz.forwardAD = reset_n & hz.regWriteM & reg_hit(hz.writeRegM, hz.rsD);
  assign hz.forwardBD = reset_n & hz.regWriteM & reg_hit(hz.writeRegM, hz.rtD);
  assign hz.forwardAE = reset_n ? fwd_ae : 2'b00;
  assign hz.forwardBE = reset_n ? fwd_be : 2'b00;
  assign hz.mdBusy    = (state != MD_IDLE);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // md_left = number of remaining cycles in which the MD unit is occupied
  // (MD_LATENCY countdown cycles plus the HI/LO write cycle).
  int md_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          md_left <= 0;
    else if (md_left > 0)  md_left <= md_left - 1;
    else if (hz.mdStartE)  md_left <= LAT + 1;
  end

  function automatic bit same(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (hz.regWriteM && same(hz.writeRegM, src)) return 2'd2;
    if (hz.regWriteW && same(hz.writeRegW, src)) return 2'd1;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    bit uses_e, uses_m, lw, br, md, st, r;
    r      = reset_n;
    uses_e = same(hz.writeRegE, hz.rsD) || same(hz.writeRegE, hz.rtD);
    uses_m = same(hz.writeRegM, hz.rsD) || same(hz.writeRegM, hz.rtD);
    lw     = hz.memToRegE && uses_e;
    br     = hz.branchD && ((hz.regWriteE && uses_e) || (hz.memToRegM && uses_m));
    md     = hz.mdOpD && (md_left > 0 || hz.mdStartE);
    st     = r && (lw || br || md);
    cmp("m_stallF", {1'b0, hz.stallF}, {1'b0, st});
    cmp("m_stallD", {1'b0, hz.stallD}, {1'b0, st});
    cmp("m_flushE", {1'b0, hz.flushE}, {1'b0, st});
    cmp("m_flushD", {1'b0, hz.flushD}, {1'b0, r && hz.PCSrcD && !st});
    cmp("m_fwdAD", {1'b0, hz.forwardAD}, {1'b0, r && hz.regWriteM && same(hz.writeRegM, hz.rsD)});
    cmp("m_fwdBD", {1'b0, hz.forwardBD}, {1'b0, r && hz.regWriteM && same(hz.writeRegM, hz.rtD)});
    cmp("m_fwdAE", hz.forwardAE, r ? m_fwd(hz.rsE) : 2'd0);
    cmp("m_fwdBE", hz.forwardBE, r ? m_fwd(hz.rtE) : 2'd0);
    cmp("m_mdBusy", {1'b0, hz.mdBusy}, {1'b0, md_left > 0});
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.writeRegE = 0; hz.writeRegM = 0; hz.writeRegW = 0;
    hz.regWriteE = 0; hz.regWriteM = 0; hz.regWriteW = 0;
    hz.memToRegE = 0; hz.memToRegM = 0; hz.branchD = 0;
    hz.PCSrcD = 0; hz.mdOpD = 0; hz.mdStartE = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    clear_in();
    // Hazard-rich inputs during reset: everything must stay quiet.
    hz.memToRegE = 1; hz.writeRegE = 8; hz.rsD = 8;
    hz.regWriteM = 1; hz.writeRegM = 9; hz.rsE = 9; hz.PCSrcD = 1;
    #2;
    cmp("rst_stallD", {1'b0, hz.stallD}, 2'd0);
    cmp("rst_flushD", {1'b0, hz.flushD}, 2'd0);
    cmp("rst_fwdAE", hz.forwardAE, 2'd0);
    cmp("rst_mdBusy", {1'b0, hz.mdBusy}, 2'd0);
    step(); step();
    reset_n = 1'b1;
    clear_in();

    // 1: load-use, one cycle
    step();
    hz.memToRegE = 1; hz.writeRegE = 8; hz.rsD = 8;
    #1;
    cmp("lw_stallF", {1'b0, hz.stallF}, 2'd1);
    cmp("lw_flushE", {1'b0, hz.flushE}, 2'd1);
    step();
    clear_in();
    #1;
    cmp("lw_release", {1'b0, hz.stallD}, 2'd0);

    // 2: bypass priority
    step();
    hz.regWriteM = 1; hz.writeRegM = 9; hz.rsE = 9;
    hz.regWriteW = 1; hz.writeRegW = 9; hz.rtE = 9;
    #1;
    cmp("byp_memwins", hz.forwardAE, 2'd2);
    cmp("byp_memwinsB", hz.forwardBE, 2'd2);
    step();
    hz.writeRegM = 0;
    #1;
    cmp("byp_wb", hz.forwardAE, 2'd1);
    step();
    clear_in();
    hz.regWriteM = 1; hz.writeRegM = 7; hz.rtD = 7;
    #1;
    cmp("byp_fwdBD", {1'b0, hz.forwardBD}, 2'd1);
    cmp("byp_fwdAD", {1'b0, hz.forwardAD}, 2'd0);

    // 3: branch hazard, redirect suppressed while stalled, then taken
    step();
    clear_in();
    hz.branchD = 1; hz.rtD = 4; hz.regWriteE = 1; hz.writeRegE = 4; hz.PCSrcD = 1;
    #1;
    cmp("br_stallD", {1'b0, hz.stallD}, 2'd1);
    cmp("br_noflushD", {1'b0, hz.flushD}, 2'd0);
    step();
    hz.regWriteE = 0; hz.writeRegE = 0;
    #1;
    cmp("br_flushD", {1'b0, hz.flushD}, 2'd1);
    cmp("br_release", {1'b0, hz.stallD}, 2'd0);
    step();
    clear_in();
    hz.branchD = 1; hz.rsD = 5; hz.memToRegM = 1; hz.writeRegM = 5;
    #1;
    cmp("br_ldM", {1'b0, hz.stallF}, 2'd1);

    // 4: MD latency 4, with a stray start pulse during BUSY
    step();
    clear_in();
    hz.mdStartE = 1; hz.mdOpD = 1;
    #1;
    cmp("md_c0_busy", {1'b0, hz.mdBusy}, 2'd0);
    cmp("md_c0_stall", {1'b0, hz.stallD}, 2'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      hz.mdStartE = (k == 2);
      #1;
      cmp($sformatf("md_c%0d_busy", k), {1'b0, hz.mdBusy}, (k <= 5) ? 2'd1 : 2'd0);
      cmp($sformatf("md_c%0d_stall", k), {1'b0, hz.stallD}, (k <= 5) ? 2'd1 : 2'd0);
    end

    // 5: reset in the middle of BUSY
    step();
    clear_in();
    hz.mdStartE = 1; hz.mdOpD = 1;
    step();
    hz.mdStartE = 0;
    step();
    hz.memToRegE = 1; hz.writeRegE = 3; hz.rsD = 3;
    #2;
    reset_n = 1'b0;
    #1;
    cmp("mdrst_busy", {1'b0, hz.mdBusy}, 2'd0);
    cmp("mdrst_stall", {1'b0, hz.stallF}, 2'd0);
    step();
    reset_n = 1'b1;
    clear_in();
    step();
    hz.mdStartE = 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      hz.mdStartE = 0;
      #1;
      if (hz.mdBusy) n++;
      else break;
    end
    cmp("mdrst_relat", n[1:0], 2'd1);   // 5 = 2'b01 in the low bits
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL mdrst_count: busy %0d cycles expected %0d", n, LAT + 1);
    end

    // 6: register zero never matches
    step();
    clear_in();
    hz.memToRegE = 1; hz.writeRegE = 0; hz.rsD = 0;
    hz.branchD = 1; hz.regWriteE = 1;
    hz.regWriteM = 1; hz.writeRegM = 0; hz.rsE = 0;
    hz.regWriteW = 1; hz.writeRegW = 0; hz.rtE = 0;
    #1;
    cmp("zero_stall", {1'b0, hz.stallD}, 2'd0);
    cmp("zero_fwdAE", hz.forwardAE, 2'd0);
    cmp("zero_fwdBE", hz.forwardBE, 2'd0);

    // Directed sweep over small register numbers, checked by the model.
    for (int i = 0; i < 160; i++) begin
      step();
      hz.rsD = 5'(i % 4);        hz.rtD = 5'((i / 4) % 4);
      hz.rsE = 5'((i / 2) % 4);  hz.rtE = 5'((i / 3) % 4);
      hz.writeRegE = 5'((i / 5) % 4);
      hz.writeRegM = 5'((i / 7) % 4);
      hz.writeRegW = 5'((i / 11) % 4);
      hz.regWriteE = i[0]; hz.regWriteM = i[1]; hz.regWriteW = i[2];
      hz.memToRegE = i[3]; hz.memToRegM = i[4];
      hz.branchD = i[1] ^ i[3]; hz.PCSrcD = i[2] ^ i[4];
      hz.mdOpD = i[5]; hz.mdStartE = (i % 19 == 0);
    end
    step();
    clear_in();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
